// File: rtl/id_inst_queue_if.sv
// IF -> decode instruction queue interface.
// master: fetch/decode side driving the queue; slave: the queue itself.
interface id_inst_queue_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int CNT_W  = 3
);
  logic              in_valid;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              in_ready;
  logic              out_valid;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_ready;
  logic              flush;
  logic              flush_keep1;
  logic [CNT_W-1:0]  count;
  logic              almost_full;
  logic              overflow;

  modport master (
    output in_valid, in_pc, in_inst, out_ready, flush, flush_keep1,
    input  in_ready, out_valid, out_pc, out_inst, count, almost_full, overflow
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready, flush, flush_keep1,
    output in_ready, out_valid, out_pc, out_inst, count, almost_full, overflow
  );
endinterface

// File: rtl/id_inst_queue.sv
// Instruction queue between IF and decode: DEPTH-entry FIFO of {pc, inst}.
// Holds fetched instructions across decode stalls, drops them on a branch
// redirect (optionally keeping the delay-slot entry) and flags almost_full
// early enough to cover the inst SRAM read latency.
// Optional: define ID_IQ_BYPASS_EN for a 0-cycle path from in_* to out_*
// when the queue is empty.
//
// state     | meaning
// ----------+----------------------------------------------
// S_EMPTY   | count == 0, nothing stored
// S_PARTIAL | 0 < count < DEPTH
// S_FULL    | count == DEPTH, write accepted only with a read
module id_inst_queue #(
  parameter int DEPTH        = 4,
  parameter int PC_W         = 32,
  parameter int INST_W       = 32,
  parameter int AFULL_MARGIN = 1
) (
  input logic             clk,
  input logic             rst,
  id_inst_queue_if.slave  q
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int DW    = PC_W + INST_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_TH    = CNT_W'(DEPTH - AFULL_MARGIN);

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DW-1:0]     r_mem [DEPTH];
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic [DW-1:0]     w_head;
  logic              w_stored_valid;
  logic              w_bypass;
  logic              w_out_valid;
  logic              w_deq;
  logic              w_deq_st;
  logic              w_byp_take;
  logic              w_in_ready;
  logic              w_enq;
  logic [CNT_W-1:0]  w_remain;
  logic              w_we;
  logic [AW-1:0]     w_rd_nxt;
  logic [AW-1:0]     w_wr_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  assign w_head         = r_mem[r_rd_ptr];
  assign w_stored_valid = (r_state != S_EMPTY);

`ifdef ID_IQ_BYPASS_EN
  // A plain flush kills the bypassed entry; a keep1 flush lets it through.
  assign w_bypass = (r_state == S_EMPTY) & q.in_valid & ~(q.flush & ~q.flush_keep1);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_out_valid = w_stored_valid | w_bypass;
  assign w_deq       = w_out_valid & q.out_ready;
  assign w_deq_st    = w_deq & w_stored_valid;
  assign w_byp_take  = w_deq & w_bypass;
  assign w_in_ready  = (r_state != S_FULL) | w_deq;
  assign w_enq       = q.in_valid & w_in_ready;
  assign w_remain    = r_count - CNT_W'(w_deq_st);

  // Next pointer/count/write-enable from handshake and flush.
  always_comb begin
    w_we      = 1'b0;
    w_rd_nxt  = r_rd_ptr;
    w_wr_nxt  = r_wr_ptr;
    w_cnt_nxt = r_count;
    if (q.flush) begin
      if (q.flush_keep1 && (w_remain != '0)) begin
        // oldest stored entry not consumed this cycle survives
        w_rd_nxt  = r_rd_ptr + AW'(w_deq_st);
        w_wr_nxt  = w_rd_nxt + AW'(1);
        w_cnt_nxt = CNT_W'(1);
      end else if (q.flush_keep1 && q.in_valid && !w_byp_take) begin
        // nothing stored survives, so the incoming entry is the delay slot
        w_we      = 1'b1;
        w_rd_nxt  = r_wr_ptr;
        w_wr_nxt  = r_wr_ptr + AW'(1);
        w_cnt_nxt = CNT_W'(1);
      end else begin
        w_rd_nxt  = r_wr_ptr;
        w_cnt_nxt = '0;
      end
    end else begin
      w_we = w_enq & ~w_byp_take;
      if (w_we)     w_wr_nxt = r_wr_ptr + AW'(1);
      if (w_deq_st) w_rd_nxt = r_rd_ptr + AW'(1);
      w_cnt_nxt = r_count + CNT_W'(w_we) - CNT_W'(w_deq_st);
    end
  end

  // FSM next state follows the next occupancy.
  always_comb begin
    w_state_nxt = S_PARTIAL;
    if (w_cnt_nxt == '0)          w_state_nxt = S_EMPTY;
    else if (w_cnt_nxt == FULL_CNT) w_state_nxt = S_FULL;
  end

  // State, pointers, count and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_wr_ptr <= w_wr_nxt;
      r_count  <= w_cnt_nxt;
      if (q.in_valid && !w_in_ready && !q.flush) r_overflow <= 1'b1;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr_ptr] <= {q.in_pc, q.in_inst};
  end

  assign q.in_ready    = w_in_ready;
  assign q.out_valid   = w_out_valid;
  assign q.out_pc      = w_bypass ? q.in_pc :
                         (w_stored_valid ? w_head[DW-1 -: PC_W] : '0);
  assign q.out_inst    = w_bypass ? q.in_inst :
                         (w_stored_valid ? w_head[INST_W-1:0] : '0);
  assign q.count       = r_count;
  assign q.almost_full = (r_count >= AF_TH);
  assign q.overflow    = r_overflow;
endmodule

// File: tb/tb_id_inst_queue.sv
// Directed bench for id_inst_queue with a queue-based scoreboard.
module tb_id_inst_queue;
  localparam int DEPTH  = 4;
  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam int CNT_W  = 3;
`ifdef ID_IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_inst_queue_if #(.PC_W(PC_W), .INST_W(INST_W), .CNT_W(CNT_W)) q ();

  id_inst_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W), .AFULL_MARGIN(1)) dut (
    .clk(clk),
    .rst(rst),
    .q  (q)
  );

  logic [63:0] sb[$];
  bit          exp_ovf;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic iv, input logic [31:0] pc, input logic ordy,
                        input logic fl, input logic fk);
    q.in_valid    = iv;
    q.in_pc       = pc;
    q.in_inst     = pc ^ 32'hA5A5_5A5A;
    q.out_ready   = ordy;
    q.flush       = fl;
    q.flush_keep1 = fk;
  endtask

  // Called at posedge+1; applies inputs for one edge and checks before/after it.
  task automatic cyc(input logic iv, input logic [31:0] pc, input logic ordy,
                     input logic fl, input logic fk);
    logic [63:0] ent, exp, keep;
    bit ev, er, deq, byp_take;
    int n;
    ent = {pc, pc ^ 32'hA5A5_5A5A};
    set_in(iv, pc, ordy, fl, fk);
    @(negedge clk);
    n  = sb.size();
    ev = (n != 0) || (BYP && iv && !(fl && !fk));
    er = (n < DEPTH) || (ev && ordy);
    chk("out_valid", {63'd0, q.out_valid}, {63'd0, ev});
    chk("in_ready",  {63'd0, q.in_ready},  {63'd0, er});
    if (ev) begin
      exp = (n != 0) ? sb[0] : ent;
      chk("out_pc",   {32'd0, q.out_pc},   {32'd0, exp[63:32]});
      chk("out_inst", {32'd0, q.out_inst}, {32'd0, exp[31:0]});
    end else begin
      chk("out_masked", {q.out_pc, q.out_inst}, 64'd0);
    end
    deq      = ev && ordy;
    byp_take = deq && (n == 0);
    if (deq && n != 0) void'(sb.pop_front());
    if (!fl) begin
      if (iv && er && !byp_take) sb.push_back(ent);
      if (iv && !er) exp_ovf = 1'b1;
    end else if (fk) begin
      if (sb.size() != 0) begin
        keep = sb[0];
        sb.delete();
        sb.push_back(keep);
      end else if (iv && !byp_take) begin
        sb.push_back(ent);
      end
    end else begin
      sb.delete();
    end
    @(posedge clk); #1;
    chk("count",       {61'd0, q.count},       64'(sb.size()));
    chk("almost_full", {63'd0, q.almost_full}, {63'd0, (sb.size() >= DEPTH - 1)});
    chk("overflow",    {63'd0, q.overflow},    {63'd0, exp_ovf});
  endtask

  // Reset held two edges with a flush and write pending to show reset wins.
  task automatic do_reset();
    set_in(1'b1, 32'hDEAD_0000, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    sb.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
    chk("rst_out_valid",   {63'd0, q.out_valid},   64'd0);
    chk("rst_out_pc",      {32'd0, q.out_pc},      64'd0);
    chk("rst_out_inst",    {32'd0, q.out_inst},    64'd0);
    chk("rst_count",       {61'd0, q.count},       64'd0);
    chk("rst_in_ready",    {63'd0, q.in_ready},    64'd1);
    chk("rst_overflow",    {63'd0, q.overflow},    64'd0);
    chk("rst_almost_full", {63'd0, q.almost_full}, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    exp_ovf = 1'b0;
    rst     = 1'b1;
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    do_reset();

    // fill to full, then an overflowing write
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hBFC0_0000 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hBFC0_0010, 1'b0, 1'b0, 1'b0);
    // full queue read and written in the same cycle, then drain
    cyc(1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // flush keep1 with a same-cycle dequeue
    cyc(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h108, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'd0,   1'b1, 1'b1, 1'b1);
    cyc(1'b0, 32'd0,   1'b1, 1'b0, 1'b0);

    // empty queue flushes with an incoming entry
    cyc(1'b1, 32'h200, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 32'd0,   1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h204, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0,   1'b1, 1'b0, 1'b0);

    // empty-queue latency (0 cycles with bypass, 1 without)
    cyc(1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'd0,   1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'd0,   1'b1, 1'b0, 1'b0);

    // full queue flush keep1 with a write pending: head survives
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h410, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 32'd0,   1'b1, 1'b0, 1'b0);

    // plain flush with dequeue and enqueue in the same cycle
    cyc(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h504, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h508, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 32'd0,   1'b1, 1'b0, 1'b0);

    // reset while entries are held and a flush is in flight
    cyc(1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h604, 1'b0, 1'b0, 1'b0);
    do_reset();
    cyc(1'b1, 32'h700, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'd0,   1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
